// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, types and helpers for the FFT datapath.
//   N_POINTS    transform length (power of two)
//   LOG2N       index width
//   BANK_AW     address width of one ram1 bank (N_POINTS/2 words)
//   DATA_W      signed width of each real/imag component
//   SCALE_SHIFT right shift used when LOADER_SCALE_EN is defined
//   bitrev()    bit-reverses an LOG2N-bit sample index
package fft_pkg;

  localparam int N_POINTS    = 1024;
  localparam int LOG2N       = 10;
  localparam int BANK_AW     = 9;
  localparam int DATA_W      = 16;
  localparam int SCALE_SHIFT = 1;

  // Index of the final sample of a frame.
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  typedef logic signed [DATA_W-1:0] sample_t;
  // Element 0 is the real part, element 1 the imaginary part.
  typedef sample_t [0:1] cplx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = x[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// fft_input_loader_if: sample stream in, ram1 bank-pair write port out.
//   i_start    arm a frame load
//   i_valid    sample present on i_data
//   i_data     complex sample [real imag]
//   o_ready    loader accepts a sample this cycle
//   o_wr_en    [even odd] bank write enables
//   o_wr_addr  write address per bank
//   o_wr_data  write data per bank, [bank][real imag]
//   o_busy     frame load in progress
//   o_done     one-cycle pulse with the final write
// master: the sample source / memory side; slave: the loader.
interface fft_input_loader_if;
  import fft_pkg::*;

  logic                       i_start;
  logic                       i_valid;
  cplx_t                      i_data;
  logic                       o_ready;
  logic [1:0]                 o_wr_en;
  logic [1:0][BANK_AW-1:0]    o_wr_addr;
  cplx_t [1:0]                o_wr_data;
  logic                       o_busy;
  logic                       o_done;

  modport master (
    output i_start, i_valid, i_data,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
  );

  modport slave (
    input  i_start, i_valid, i_data,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done
  );

endinterface

// File: rtl/fft_addr_map.sv
// fft_addr_map: maps a natural-order sample index to its ram1 location.
// The bit-reversed index selects the bank with its LSB (0 = even bank,
// 1 = odd bank) and the word with its upper bits.
//   count  natural-order sample index
//   bank   bank select
//   addr   word address within the bank
module fft_addr_map
  import fft_pkg::*;
(
  input  logic [LOG2N-1:0]   count,
  output logic               bank,
  output logic [BANK_AW-1:0] addr
);

  logic [LOG2N-1:0] rev_s;

  // Split the reversed index into bank select and bank address.
  always_comb begin
    rev_s = bitrev(count);
    bank  = rev_s[0];
    addr  = rev_s[LOG2N-1:1];
  end

endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: streaming front-end of the 1024-point FFT. Accepts
// samples over valid/ready while armed, writes each one to the ram1
// even/odd bank pair at its bit-reversed location one cycle after the
// handshake, and pulses o_done together with the final write.
//   i_clk  clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    fft_input_loader_if.slave (stream in, bank writes out)
// Build option: LOADER_SCALE_EN arithmetic-shifts each component right
// by SCALE_SHIFT before it is written; undefined writes bit-exact data.
module fft_input_loader
  import fft_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  fft_input_loader_if.slave bus
);

  state_t                  state_r;
  logic [LOG2N-1:0]        count_r;
  logic                    ready_r;
  logic                    done_r;
  logic [1:0]              wr_en_r;
  logic [1:0][BANK_AW-1:0] wr_addr_r;
  cplx_t [1:0]             wr_data_r;

  logic                    accept_s;
  logic                    bank_s;
  logic [BANK_AW-1:0]      addr_s;
  cplx_t                   data_s;

  fft_addr_map u_addr_map (
    .count (count_r),
    .bank  (bank_s),
    .addr  (addr_s)
  );

`ifdef LOADER_SCALE_EN
  // Sign-preserving shift, truncating toward -inf; no saturation needed.
  function automatic sample_t scale(input sample_t x);
    return x >>> SCALE_SHIFT;
  endfunction

  assign data_s[0] = scale(bus.i_data[0]);
  assign data_s[1] = scale(bus.i_data[1]);
`else
  assign data_s = bus.i_data;
`endif

  // ready_r mirrors state==LOAD, so the handshake never depends on i_valid.
  assign accept_s = bus.i_valid && ready_r;

  // Frame FSM, index counter and one-cycle-latency bank write registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      count_r   <= {LOG2N{1'b0}};
      ready_r   <= 1'b0;
      done_r    <= 1'b0;
      wr_en_r   <= 2'b00;
      wr_addr_r <= {(2*BANK_AW){1'b0}};
      wr_data_r <= {(4*DATA_W){1'b0}};
    end else begin
      wr_en_r <= 2'b00;
      done_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          count_r <= {LOG2N{1'b0}};
          if (bus.i_start) begin
            state_r <= ST_LOAD;
            ready_r <= 1'b1;
          end else begin
            ready_r <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (accept_s) begin
            // Only the selected bank updates; the other holds addr/data.
            wr_en_r[bank_s]   <= 1'b1;
            wr_addr_r[bank_s] <= addr_s;
            wr_data_r[bank_s] <= data_s;
            count_r           <= count_r + {{(LOG2N-1){1'b0}}, 1'b1};
            if (count_r == LAST_IDX) begin
              state_r <= ST_DONE;
              ready_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              ready_r <= 1'b1;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          count_r <= {LOG2N{1'b0}};
          ready_r <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          count_r <= {LOG2N{1'b0}};
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready   = ready_r;
  assign bus.o_busy    = ready_r;
  assign bus.o_done    = done_r;
  assign bus.o_wr_en   = wr_en_r;
  assign bus.o_wr_addr = wr_addr_r;
  assign bus.o_wr_data = wr_data_r;

endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: scoreboard bench for fft_input_loader. A cycle model
// predicts the handshake; each accepted sample pushes its expected bank
// write, which is popped and compared when the write strobe appears.
module tb_fft_input_loader;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fft_input_loader_if bus ();

  fft_input_loader dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    int                 idx;
    logic               bank;
    logic [8:0]         addr;
    logic signed [15:0] re;
    logic signed [15:0] im;
  } wr_t;

`ifdef LOADER_SCALE_EN
  localparam int EXP_RE0 = -2;
  localparam int EXP_IM0 = 2;
`else
  localparam int EXP_RE0 = -3;
  localparam int EXP_IM0 = 5;
`endif

  int total = 0;
  int bad   = 0;

  wr_t sb[$];
  wr_t e;

  // cycle model: 0 idle, 1 load, 2 done
  int   m_state = 0;
  int   m_cnt   = 0;
  logic m_done  = 1'b0;
  logic m_exp_wr = 1'b0;
  logic mon_en  = 1'b0;

  logic [8:0]         last_addr [2];
  logic signed [15:0] last_re   [2];
  logic signed [15:0] last_im   [2];

  int                 obs_bank [1024];
  int                 obs_addr [1024];
  logic signed [15:0] obs_re   [1024];
  logic signed [15:0] obs_im   [1024];
  logic signed [15:0] img_re   [2][512];
  logic signed [15:0] img_im   [2][512];
  logic signed [15:0] ref_re   [2][512];
  logic signed [15:0] ref_im   [2][512];
  int                 wcnt [2];
  int                 done_cnt;
  logic               done_last;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] tb_rev(input int c);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = c[9-i];
    return r;
  endfunction

  function automatic logic signed [15:0] exp_val(input logic signed [15:0] x);
`ifdef LOADER_SCALE_EN
    return x >>> 1;
`else
    return x;
`endif
  endfunction

  task automatic clear_obs();
    for (int i = 0; i < 1024; i++) begin
      obs_bank[i] = -1;
      obs_addr[i] = -1;
      obs_re[i]   = 16'sd0;
      obs_im[i]   = 16'sd0;
    end
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 512; a++) begin
        img_re[b][a] = 16'sd0;
        img_im[b][a] = 16'sd0;
      end
    end
    wcnt[0] = 0;
    wcnt[1] = 0;
    done_cnt = 0;
    done_last = 1'b0;
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_cnt    = 0;
    m_done   = 1'b0;
    m_exp_wr = 1'b0;
    sb.delete();
    for (int b = 0; b < 2; b++) begin
      last_addr[b] = 9'd0;
      last_re[b]   = 16'sd0;
      last_im[b]   = 16'sd0;
    end
  endtask

  // Drive one cycle of inputs, push the expected write, step the model.
  task automatic tick(input logic start, input logic valid,
                      input logic signed [15:0] re, input logic signed [15:0] im);
    logic       acc;
    logic [9:0] r;
    wr_t        w;
    bus.i_start   = start;
    bus.i_valid   = valid;
    bus.i_data[0] = re;
    bus.i_data[1] = im;
    acc = valid && (m_state == 1);
    if (acc) begin
      r      = tb_rev(m_cnt);
      w.idx  = m_cnt;
      w.bank = r[0];
      w.addr = r[9:1];
      w.re   = exp_val(re);
      w.im   = exp_val(im);
      sb.push_back(w);
    end
    @(posedge clk);
    m_exp_wr = acc;
    m_done   = 1'b0;
    case (m_state)
      0: if (start) m_state = 1;
      1: if (acc) begin
           if (m_cnt == 1023) begin
             m_state = 2;
             m_done  = 1'b1;
           end
           m_cnt = (m_cnt + 1) % 1024;
         end
      default: begin
        m_state = 0;
        m_cnt   = 0;
      end
    endcase
    #1;
  endtask

  // Reset asserted between clock edges; outputs must clear at once.
  task automatic async_reset();
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready", bus.o_ready, 1'b0);
    chk("arst_busy",  bus.o_busy,  1'b0);
    chk("arst_wr_en", bus.o_wr_en, 2'b00);
    chk("arst_addr",  bus.o_wr_addr, 18'd0);
    chk("arst_data",  bus.o_wr_data, 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("ready", bus.o_ready, m_state == 1);
      chk("busy",  bus.o_busy,  m_state == 1);
      chk("done",  bus.o_done,  m_done);
      if (bus.o_done) done_cnt++;
      if (m_exp_wr) begin
        if (sb.size() == 0) begin
          chk("sb_size", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("wr_en", bus.o_wr_en, e.bank ? 2'b10 : 2'b01);
          chk("addr",  bus.o_wr_addr[e.bank], e.addr);
          chk("re",    bus.o_wr_data[e.bank][0], e.re);
          chk("im",    bus.o_wr_data[e.bank][1], e.im);
          chk("hold_addr", bus.o_wr_addr[!e.bank], last_addr[!e.bank]);
          chk("hold_re",   bus.o_wr_data[!e.bank][0], last_re[!e.bank]);
          last_addr[e.bank] = e.addr;
          last_re[e.bank]   = e.re;
          last_im[e.bank]   = e.im;
          obs_bank[e.idx] = int'(bus.o_wr_en[1]);
          obs_addr[e.idx] = int'(bus.o_wr_addr[bus.o_wr_en[1]]);
          obs_re[e.idx]   = bus.o_wr_data[bus.o_wr_en[1]][0];
          obs_im[e.idx]   = bus.o_wr_data[bus.o_wr_en[1]][1];
          img_re[bus.o_wr_en[1]][bus.o_wr_addr[bus.o_wr_en[1]]] = bus.o_wr_data[bus.o_wr_en[1]][0];
          img_im[bus.o_wr_en[1]][bus.o_wr_addr[bus.o_wr_en[1]]] = bus.o_wr_data[bus.o_wr_en[1]][1];
          if (bus.o_wr_en == 2'b01) wcnt[0]++;
          if (bus.o_wr_en == 2'b10) wcnt[1]++;
          if (e.idx == 1023) done_last = bus.o_done;
        end
      end else begin
        chk("no_wr", bus.o_wr_en, 2'b00);
      end
    end
  end

  task automatic run_frame(input int duty, input bit mid_start,
                           input bit special0, input int abort_at);
    int   guard;
    logic v;
    logic st;
    logic signed [15:0] re;
    logic signed [15:0] im;
    clear_obs();
    tick(1'b1, 1'b0, 16'sd0, 16'sd0);
    guard = 0;
    while (m_state == 1 && guard < 8000) begin
      if (abort_at >= 0 && m_cnt == abort_at) begin
        async_reset();
        return;
      end
      v  = ($urandom_range(0, 99) < duty);
      re = 16'(m_cnt);
      im = -16'(m_cnt);
      if (special0 && m_cnt == 0) begin
        re = -16'sd3;
        im = 16'sd5;
      end
      st = mid_start && (m_cnt == 300);
      guard++;
      tick(st, v, re, im);
    end
    chk("guard", guard < 8000, 1'b1);
    // extra sample right after the final accept must not be consumed
    tick(1'b0, 1'b1, 16'sd1024, 16'sd77);
    tick(1'b0, 1'b0, 16'sd0, 16'sd0);
    bus.i_valid = 1'b0;
  endtask

  task automatic check_image_ref();
    int errs;
    logic [9:0] r;
    errs = 0;
    for (int c = 0; c < 1024; c++) begin
      r = tb_rev(c);
      if (img_re[r[0]][r[9:1]] !== exp_val(16'(c))) errs++;
      if (img_im[r[0]][r[9:1]] !== exp_val(-16'(c))) errs++;
    end
    chk("img_ref", errs, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.i_start   = 1'b0;
    bus.i_valid   = 1'b0;
    bus.i_data[0] = 16'sd0;
    bus.i_data[1] = 16'sd0;
    model_reset();
    clear_obs();
    #3;
    chk("rst_ready", bus.o_ready, 1'b0);
    chk("rst_busy",  bus.o_busy,  1'b0);
    chk("rst_done",  bus.o_done,  1'b0);
    chk("rst_wr_en", bus.o_wr_en, 2'b00);
    chk("rst_addr",  bus.o_wr_addr, 18'd0);
    chk("rst_data",  bus.o_wr_data, 64'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;

    // valid without start: nothing accepted
    repeat (5) tick(1'b0, 1'b1, 16'sd7, 16'sd9);
    chk("nostart_ready", bus.o_ready, 1'b0);

    // back-to-back frame with a stray start at count 300
    run_frame(100, 1'b1, 1'b0, -1);
    chk("c0_bank",    obs_bank[0], 0);
    chk("c0_addr",    obs_addr[0], 0);
    chk("c1_bank",    obs_bank[1], 0);
    chk("c1_addr",    obs_addr[1], 256);
    chk("c2_addr",    obs_addr[2], 128);
    chk("c512_bank",  obs_bank[512], 1);
    chk("c512_addr",  obs_addr[512], 0);
    chk("c1023_bank", obs_bank[1023], 1);
    chk("c1023_addr", obs_addr[1023], 511);
    chk("even_cnt",   wcnt[0], 512);
    chk("odd_cnt",    wcnt[1], 512);
    chk("done_cnt",   done_cnt, 1);
    chk("done_last",  done_last, 1'b1);
    chk("sb_left",    sb.size(), 0);
    check_image_ref();
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 512; a++) begin
        ref_re[b][a] = img_re[b][a];
        ref_im[b][a] = img_im[b][a];
      end
    end

    // same frame with ~40% valid duty
    run_frame(40, 1'b0, 1'b0, -1);
    begin
      int diffs;
      diffs = 0;
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < 512; a++) begin
          if (img_re[b][a] !== ref_re[b][a] || img_im[b][a] !== ref_im[b][a]) diffs++;
        end
      end
      chk("img_bubble", diffs, 0);
    end
    chk("bub_even_cnt", wcnt[0], 512);
    chk("bub_odd_cnt",  wcnt[1], 512);
    chk("bub_done_cnt", done_cnt, 1);

    // (-3,5) as first sample, then asynchronous reset at count 700
    run_frame(100, 1'b0, 1'b1, 700);
    chk("scale_re", obs_re[0], EXP_RE0);
    chk("scale_im", obs_im[0], EXP_IM0);
    chk("abort_done_cnt", done_cnt, 0);

    // reload after reset starts again from count 0
    run_frame(100, 1'b0, 1'b0, -1);
    chk("reload_c0_bank", obs_bank[0], 0);
    chk("reload_c0_addr", obs_addr[0], 0);
    chk("reload_done_cnt", done_cnt, 1);
    check_image_ref();

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
